// File: rtl/lagarto_pmu_pkg.sv
// Lagarto PMU counters: shared address map, select width and register decode.
package lagarto_pmu_pkg;

    // Width of an event-select field (selects events 0..31).
    localparam int unsigned SEL_W = 5;

    // Word address width of the register port.
    localparam int unsigned ADDR_W = 5;

    // Number of slots in the counter window and in the select window.
    localparam int unsigned WINDOW = 8;

    // Register address map.
    localparam logic [ADDR_W-1:0] ADDR_CNT_BASE = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_SEL_BASE = 5'd8;
    localparam logic [ADDR_W-1:0] ADDR_INHIBIT  = 5'd16;
    localparam logic [ADDR_W-1:0] ADDR_OVF      = 5'd17;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_EN   = 5'd18;

    // Which register class an address selects.
    typedef enum logic [2:0] {
        REG_COUNTER    = 3'd0,
        REG_SELECT     = 3'd1,
        REG_INHIBIT    = 3'd2,
        REG_OVF_STATUS = 3'd3,
        REG_IRQ_EN     = 3'd4,
        REG_ERROR      = 3'd5
    } reg_idx_e;

    // Classify a word address. Counter and select slots beyond the number
    // of implemented counters decode as errors. The counter window is only
    // 8 words wide, so with more than 8 counters the upper ones are not
    // reachable through the register port (they still count).
    function automatic reg_idx_e decode_addr(input logic [ADDR_W-1:0] addr,
                                             input int unsigned num_cnt);
        reg_idx_e    idx;
        int unsigned slot;
        slot = {29'd0, addr[2:0]};
        if (addr < ADDR_SEL_BASE) begin
            idx = (slot < num_cnt) ? REG_COUNTER : REG_ERROR;
        end else if (addr < ADDR_INHIBIT) begin
            idx = (slot < num_cnt) ? REG_SELECT : REG_ERROR;
        end else if (addr == ADDR_INHIBIT) begin
            idx = REG_INHIBIT;
        end else if (addr == ADDR_OVF) begin
            idx = REG_OVF_STATUS;
        end else if (addr == ADDR_IRQ_EN) begin
            idx = REG_IRQ_EN;
        end else begin
            idx = REG_ERROR;
        end
        return idx;
    endfunction

endpackage

// File: rtl/lagarto_pmu_counter.sv
// Single PMU counter: software write beats increment; reports wrap-around.
module lagarto_pmu_counter
    import lagarto_pmu_pkg::*;
#(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc_i,
    input  logic             wr_en_i,
    input  logic [CNT_W-1:0] wr_data_i,
    output logic [CNT_W-1:0] value_o,
    output logic             ovf_pulse_o
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    // A write discards a coincident increment, so it can never signal a wrap.
    assign ovf_pulse_o = inc_i && !wr_en_i && (value_q == {CNT_W{1'b1}});

    // Next value: write wins, otherwise count up by one (wrapping).
    always_comb begin
        value_d = value_q;
        if (wr_en_i) begin
            value_d = wr_data_i;
        end else if (inc_i) begin
            value_d = value_q + CNT_W'(1);
        end
    end

    // Counter state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/lagarto_pmu_counters.sv
// Lagarto PMU counter bank: event sampling, programmable counters,
// overflow status/interrupt and a one-cycle-latency register port.
module lagarto_pmu_counters
    import lagarto_pmu_pkg::*;
#(
    parameter int unsigned NUM_EVENTS = 23,
    parameter int unsigned NUM_CNT    = 8,
    parameter int unsigned CNT_W      = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_EVENTS-1:0] pmu_sig_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [4:0]            req_addr_i,
    input  logic [CNT_W-1:0]      req_wdata_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [CNT_W-1:0]      rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  irq_o
);

    // Event sample stage; widened so any 5-bit select indexes a defined bit.
    logic [NUM_EVENTS-1:0] sample_q;
    logic [31:0]           sample_ext;

    // Programmable state.
    logic [SEL_W-1:0]   sel_q [NUM_CNT];
    logic [NUM_CNT-1:0] inhibit_q, inhibit_d;
    logic [NUM_CNT-1:0] ovf_q, ovf_d;
    logic [NUM_CNT-1:0] irq_en_q, irq_en_d;

    // Response registers.
    logic             rsp_valid_q, rsp_valid_d;
    logic [CNT_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    // Per-counter wiring.
    logic [CNT_W-1:0]   cnt_value [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_inc;
    logic [NUM_CNT-1:0] cnt_wr_en;
    logic [NUM_CNT-1:0] sel_wr_en;
    logic [NUM_CNT-1:0] ovf_pulse;

    // Request decode.
    reg_idx_e         req_idx;
    logic [2:0]       req_slot;
    logic             req_accept;
    logic             reg_wr;
    logic [CNT_W-1:0] rd_data;
    logic [NUM_CNT-1:0] ovf_w1c;

    assign sample_ext = 32'(sample_q);

    assign req_idx    = decode_addr(req_addr_i, NUM_CNT);
    assign req_slot   = req_addr_i[2:0];
    assign req_ready_o = !(rsp_valid_q && !rsp_ready_i);
    assign req_accept = req_valid_i && req_ready_o;
    // Writes to unmapped addresses have no side effect.
    assign reg_wr     = req_accept && req_we_i && (req_idx != REG_ERROR);

    // Capture event pulses; counting uses the previous cycle's events.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= '0;
        end else begin
            sample_q <= pmu_sig_i;
        end
    end

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        logic slot_hit;

        if (gi < WINDOW) begin : g_addressable
            assign slot_hit = (req_slot == 3'(gi));
        end else begin : g_hidden
            assign slot_hit = 1'b0;
        end

        assign cnt_wr_en[gi] = reg_wr && (req_idx == REG_COUNTER) && slot_hit;
        assign sel_wr_en[gi] = reg_wr && (req_idx == REG_SELECT) && slot_hit;

        // Select values naming a non-existent event never count.
        assign cnt_inc[gi] = !inhibit_q[gi]
                          && (32'(sel_q[gi]) < NUM_EVENTS)
                          && sample_ext[sel_q[gi]];

        lagarto_pmu_counter #(
            .CNT_W (CNT_W)
        ) u_counter (
            .clk_i       (clk_i),
            .rst_ni      (rst_ni),
            .inc_i       (cnt_inc[gi]),
            .wr_en_i     (cnt_wr_en[gi]),
            .wr_data_i   (req_wdata_i),
            .value_o     (cnt_value[gi]),
            .ovf_pulse_o (ovf_pulse[gi])
        );
    end

    // Event select registers, one per counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                sel_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (sel_wr_en[i]) begin
                    sel_q[i] <= req_wdata_i[SEL_W-1:0];
                end
            end
        end
    end

    // Control register next state; a fresh overflow beats a coincident W1C.
    always_comb begin
        inhibit_d = inhibit_q;
        irq_en_d  = irq_en_q;
        ovf_w1c   = '0;
        if (reg_wr && (req_idx == REG_INHIBIT)) begin
            inhibit_d = req_wdata_i[NUM_CNT-1:0];
        end
        if (reg_wr && (req_idx == REG_IRQ_EN)) begin
            irq_en_d = req_wdata_i[NUM_CNT-1:0];
        end
        if (reg_wr && (req_idx == REG_OVF_STATUS)) begin
            ovf_w1c = req_wdata_i[NUM_CNT-1:0];
        end
        ovf_d = (ovf_q & ~ovf_w1c) | ovf_pulse;
    end

    // Control register state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inhibit_q <= '0;
            irq_en_q  <= '0;
            ovf_q     <= '0;
        end else begin
            inhibit_q <= inhibit_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
        end
    end

    // Read mux over the pre-update register state; narrow fields zero-extend.
    always_comb begin
        rd_data = '0;
        case (req_idx)
            REG_COUNTER: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if ((i < WINDOW) && (req_slot == 3'(i))) begin
                        rd_data = cnt_value[i];
                    end
                end
            end
            REG_SELECT: begin
                for (int i = 0; i < NUM_CNT; i++) begin
                    if ((i < WINDOW) && (req_slot == 3'(i))) begin
                        rd_data = CNT_W'(sel_q[i]);
                    end
                end
            end
            REG_INHIBIT:    rd_data = CNT_W'(inhibit_q);
            REG_OVF_STATUS: rd_data = CNT_W'(ovf_q);
            REG_IRQ_EN:     rd_data = CNT_W'(irq_en_q);
            default:        rd_data = '0;
        endcase
    end

    // Response next state: load on accept, otherwise hold until consumed.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (req_accept) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = req_we_i ? '0 : rd_data;
            rsp_err_d   = (req_idx == REG_ERROR);
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response registers; reset drops any pending response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign irq_o       = |(ovf_q & irq_en_q);

endmodule

// File: tb/tb_lagarto_pmu_counters.sv
// Self-checking bench for lagarto_pmu_counters: register table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_lagarto_pmu_counters;

    localparam int NE = 23;
    localparam int NC = 8;
    localparam int CW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NE-1:0] pmu_sig;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [4:0]    req_addr;
    logic [CW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [CW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          irq;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    lagarto_pmu_counters #(
        .NUM_EVENTS (NE),
        .NUM_CNT    (NC),
        .CNT_W      (CW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pmu_sig_i   (pmu_sig),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .irq_o       (irq)
    );

    // ---------------- behavioural model ----------------
    logic [63:0]   m_cnt [NC];
    logic [4:0]    m_sel [NC];
    logic [NC-1:0] m_inh, m_ovf, m_en;
    logic [NE-1:0] m_prev;
    logic          m_rv, m_re;
    logic [63:0]   m_rd;

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = '0;
            m_sel[i] = '0;
        end
        m_inh = '0; m_ovf = '0; m_en = '0; m_prev = '0;
        m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
    endfunction

    // Register map as seen by software.
    function automatic logic [63:0] model_read(input logic [4:0] a, output logic err);
        err = 1'b0;
        if (a < 8) begin
            if (int'(a) < NC) return m_cnt[a];
        end else if (a < 16) begin
            if (int'(a) - 8 < NC) return {59'd0, m_sel[int'(a) - 8]};
        end else if (a == 16) begin
            return 64'(m_inh);
        end else if (a == 17) begin
            return 64'(m_ovf);
        end else if (a == 18) begin
            return 64'(m_en);
        end
        err = 1'b1;
        return '0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Check outputs for the current cycle, advance the model and the DUT by one clock.
    task automatic step();
        logic          rdy_exp, acc, wr, err, seen;
        logic [63:0]   rd;
        logic [63:0]   n_cnt [NC];
        logic [4:0]    n_sel [NC];
        logic [NC-1:0] n_inh, n_en, n_ovf, new_ovf, clr;
        logic          n_rv, n_re;
        logic [63:0]   n_rd;
        #1;
        rdy_exp = !(m_rv && !rsp_ready);
        chk("req_ready", 64'(req_ready), 64'(rdy_exp));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        if (m_rv) begin
            chk("rsp_rdata", rsp_rdata, m_rd);
            chk("rsp_err", 64'(rsp_err), 64'(m_re));
        end
        chk("irq", 64'(irq), 64'(|(m_ovf & m_en)));

        acc = req_valid && rdy_exp;
        rd  = model_read(req_addr, err);
        wr  = acc && req_we && !err;
        n_cnt = m_cnt; n_sel = m_sel;
        n_inh = m_inh; n_en = m_en; new_ovf = '0; clr = '0;
        for (int i = 0; i < NC; i++) begin
            seen = 1'b0;
            if (m_sel[i] < NE && !m_inh[i]) seen = m_prev[m_sel[i]];
            if (wr && req_addr == 5'(i)) begin
                n_cnt[i] = req_wdata;
            end else if (seen) begin
                n_cnt[i] = m_cnt[i] + 64'd1;
                if (n_cnt[i] == 64'd0) new_ovf[i] = 1'b1;
            end
            if (wr && req_addr == 5'(8 + i)) n_sel[i] = req_wdata[4:0];
        end
        if (wr && req_addr == 5'd16) n_inh = req_wdata[NC-1:0];
        if (wr && req_addr == 5'd18) n_en  = req_wdata[NC-1:0];
        if (wr && req_addr == 5'd17) clr   = req_wdata[NC-1:0];
        n_ovf = (m_ovf & ~clr) | new_ovf;
        n_rv = m_rv; n_rd = m_rd; n_re = m_re;
        if (acc) begin
            n_rv = 1'b1;
            n_rd = req_we ? 64'd0 : rd;
            n_re = err;
        end else if (rsp_ready) begin
            n_rv = 1'b0;
        end

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_cnt = n_cnt; m_sel = n_sel; m_inh = n_inh; m_en = n_en;
            m_ovf = n_ovf; m_prev = pmu_sig;
            m_rv = n_rv; m_rd = n_rd; m_re = n_re;
        end
        #1;
    endtask

    // One accepted request with the response consumed on the following cycle.
    task automatic do_req(input logic we, input logic [4:0] addr, input logic [63:0] wdata,
                          output logic [63:0] rdata, output logic err);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
        step();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rdata = rsp_rdata;
        err   = rsp_err;
        $display("[TB] %s addr=%0d wdata=0x%0h -> rdata=0x%0h err=%0d",
                 we ? "WR" : "RD", addr, wdata, rdata, err);
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs [16];
        logic [63:0] rd, held;
        logic        er;

        rst_n = 1'b0; pmu_sig = NE'(1); req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset rsp_rdata", rsp_rdata, 64'd0);
        chk("reset rsp_err", 64'(rsp_err), 64'd0);
        chk("reset irq", 64'(irq), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // ---------- register table ----------
        vecs[0]  = '{1'b0, 5'd16, 64'd0, 64'd0, 1'b0};
        vecs[1]  = '{1'b0, 5'd17, 64'd0, 64'd0, 1'b0};
        vecs[2]  = '{1'b0, 5'd18, 64'd0, 64'd0, 1'b0};
        vecs[3]  = '{1'b1, 5'd16, 64'hFFFF_FFFF_FFFF_FF5A, 64'd0, 1'b0};
        vecs[4]  = '{1'b0, 5'd16, 64'd0, 64'h5A, 1'b0};
        vecs[5]  = '{1'b1, 5'd18, 64'hFFFF_0000_0000_00A5, 64'd0, 1'b0};
        vecs[6]  = '{1'b0, 5'd18, 64'd0, 64'hA5, 1'b0};
        vecs[7]  = '{1'b1, 5'd9,  64'hFFFF_FFE3, 64'd0, 1'b0};
        vecs[8]  = '{1'b0, 5'd9,  64'd0, 64'd3, 1'b0};
        vecs[9]  = '{1'b0, 5'd19, 64'd0, 64'd0, 1'b1};
        vecs[10] = '{1'b1, 5'd31, 64'd123, 64'd0, 1'b1};
        vecs[11] = '{1'b0, 5'd31, 64'd0, 64'd0, 1'b1};
        vecs[12] = '{1'b0, 5'd15, 64'd0, 64'd0, 1'b0};
        vecs[13] = '{1'b1, 5'd16, 64'd0, 64'd0, 1'b0};
        vecs[14] = '{1'b1, 5'd18, 64'd0, 64'd0, 1'b0};
        vecs[15] = '{1'b1, 5'd9,  64'd0, 64'd0, 1'b0};
        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
            chk($sformatf("table[%0d] rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("table[%0d] err", i), 64'(er), 64'(vecs[i].exp_err));
        end

        // ---------- cycle counting over 100 cycles ----------
        do_req(1'b1, 5'd8, 64'd0, rd, er);
        do_req(1'b1, 5'd0, 64'd0, rd, er);
        repeat (100) step();
        do_req(1'b0, 5'd0, 64'd0, rd, er);
        tests++;
        if (rd < 64'd98 || rd > 64'd102 || er !== 1'b0) begin
            fails++;
            $display("FAIL cycle count: got %0d err %0d, expected 100+-2 err 0", rd, er);
        end

        // ---------- write beats a coincident increment ----------
        do_req(1'b1, 5'd10, 64'd1, rd, er);
        pmu_sig[1] = 1'b1;
        step();
        pmu_sig[1] = 1'b0;
        do_req(1'b1, 5'd2, 64'h10, rd, er);
        step(); step();
        do_req(1'b0, 5'd2, 64'd0, rd, er);
        chk("write priority value", rd, 64'h10);
        do_req(1'b0, 5'd17, 64'd0, rd, er);
        chk("write priority no ovf", 64'(rd[2]), 64'd0);

        // ---------- response backpressure ----------
        do_req(1'b1, 5'd18, 64'h3C, rd, er);
        do_req(1'b1, 5'd16, 64'h80, rd, er);
        step();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd18; rsp_ready = 1'b0;
        step();
        held = rsp_rdata;
        chk("bp first rdata", held, 64'h3C);
        req_addr = 5'd16;
        for (int i = 0; i < 3; i++) begin
            chk("bp req_ready low", 64'(req_ready), 64'd0);
            step();
            chk("bp rdata stable", rsp_rdata, 64'h3C);
            chk("bp valid held", 64'(rsp_valid), 64'd1);
        end
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        chk("bp b2b valid", 64'(rsp_valid), 64'd1);
        chk("bp b2b rdata", rsp_rdata, 64'h80);
        do_req(1'b1, 5'd16, 64'd0, rd, er);
        do_req(1'b1, 5'd18, 64'd0, rd, er);

        // ---------- errors and out-of-range select ----------
        do_req(1'b0, 5'd25, 64'd0, rd, er);
        chk("addr 25 err", 64'(er), 64'd1);
        chk("addr 25 rdata", rd, 64'd0);
        do_req(1'b1, 5'd11, 64'd30, rd, er);
        do_req(1'b1, 5'd3, 64'd0, rd, er);
        pmu_sig = '1;
        repeat (10) step();
        pmu_sig = NE'(1);
        step(); step();
        do_req(1'b0, 5'd3, 64'd0, rd, er);
        chk("sel 30 counter stays 0", rd, 64'd0);
        do_req(1'b0, 5'd11, 64'd0, rd, er);
        chk("sel 30 readback", rd, 64'd30);

        // ---------- overflow and interrupt ----------
        do_req(1'b1, 5'd9, 64'd5, rd, er);
        do_req(1'b1, 5'd18, 64'd2, rd, er);
        do_req(1'b1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, rd, er);
        chk("irq before wrap", 64'(irq), 64'd0);
        for (int i = 0; i < 3; i++) begin
            pmu_sig[5] = 1'b1;
            step();
        end
        pmu_sig[5] = 1'b0;
        step(); step();
        do_req(1'b0, 5'd1, 64'd0, rd, er);
        chk("wrap value", rd, 64'd1);
        do_req(1'b0, 5'd17, 64'd0, rd, er);
        chk("wrap status bit1", 64'(rd[1]), 64'd1);
        chk("wrap irq", 64'(irq), 64'd1);

        // ---------- reset with a pending response ----------
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd17; rsp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst rsp_rdata", rsp_rdata, 64'd0);
        chk("rst rsp_err", 64'(rsp_err), 64'd0);
        chk("rst irq", 64'(irq), 64'd0);
        chk("rst req_ready", 64'(req_ready), 64'd1);
        model_reset();
        step(); step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        repeat (4) begin
            step();
            chk("post-reset no rsp", 64'(rsp_valid), 64'd0);
        end

        // ---------- randomized run against the model ----------
        for (int n = 0; n < 2500; n++) begin
            pmu_sig   = NE'($urandom()) | NE'(1);
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                    : 5'($urandom_range(0, 18));
            if (req_addr < 8 && $urandom_range(0, 1) == 1)
                req_wdata = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            else if (req_addr >= 8 && req_addr < 16 && $urandom_range(0, 1) == 1)
                req_wdata = 64'($urandom_range(0, 22));
            else
                req_wdata = {$urandom(), $urandom()};
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
